el2_dec_ib_buf: RTL
===================

EL2_DEC_IB_BUF -- requirements
Module: el2_dec_ib_buf

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2, meaning the number of buffered instruction entries; legal values are 2 and 4.
REQ-002 The module SHALL have port clk, input, 1 bit: the single core clock.
REQ-003 The module SHALL have port rst_l, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have port aln_valid, input, 1 bit: the aligner presents an instruction.
REQ-005 The module SHALL have port aln_instr, input, 32 bits: the aligned instruction.
REQ-006 The module SHALL have port aln_pc, input, 31 bits [31:1]: the instruction PC.
REQ-007 The module SHALL have the following 1-bit inputs: aln_pc4 (4B instruction), aln_icaf (access fault), aln_icaf_f1 (fault on second fetch group), aln_dbecc (double-bit error).
REQ-008 The module SHALL have port aln_icaf_type, input, 2 bits: the access fault type.
REQ-009 The module SHALL have port aln_ready, output, 1 bit: the buffer accepts an entry this cycle.
REQ-010 The module SHALL have port dec_ready, input, 1 bit: decode consumes the head entry.
REQ-011 The module SHALL have port dbg_cmd_valid, input, 1 bit: a debug command owns decode this cycle.
REQ-012 The module SHALL have port flush, input, 1 bit: a pipeline flush (exu_flush_final).
REQ-013 The module SHALL have the following outputs to decode, each carrying head-entry fields: ifu_i0_valid (1), ifu_i0_instr (32), ifu_i0_pc (31, [31:1]), ifu_i0_pc4 (1), ifu_i0_icaf (1), ifu_i0_icaf_type (2), ifu_i0_icaf_f1 (1), ifu_i0_dbecc (1).
REQ-014 The module SHALL have port ib_count, output, $clog2(DEPTH)+1 bits: the current occupancy.

Function
REQ-015 Each entry SHALL hold a 69-bit payload {icaf_f1, dbecc, icaf, icaf_type[1:0], pc[31:1], pc4, instr[31:0]}.
REQ-016 The module SHALL assert aln_ready = (ib_count < DEPTH), computed from registered state only, with no combinational path from dec_ready, dbg_cmd_valid or flush.
REQ-017 A push SHALL occur when aln_valid & aln_ready & ~flush; the payload is written at the write pointer on the rising clk edge.
REQ-018 A pop SHALL occur when ifu_i0_valid & dec_ready & ~dbg_cmd_valid & ~flush; the read pointer advances on the rising clk edge.
REQ-019 When dbg_cmd_valid=1, the buffer SHALL hold its head entry (no pop), regardless of dec_ready.
REQ-020 Latency: an entry pushed at edge N SHALL be visible on the ifu_i0_* outputs after edge N (cycle N+1) if the buffer was empty; there is no same-cycle bypass.
REQ-021 ifu_i0_valid SHALL equal (ib_count != 0).
REQ-022 When ifu_i0_valid=0, all ifu_i0_* payload outputs SHALL be driven to 0.
REQ-023 On a simultaneous push and pop, the count SHALL be unchanged and both pointers SHALL advance.
REQ-024 Pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH; entries SHALL be delivered in strict FIFO order across a wrap.
REQ-025 On flush=1, the next edge SHALL set ib_count=0 and both pointers to 0, and SHALL drop any concurrent push or pop; flush has priority over all other events.
REQ-026 ib_count SHALL never exceed DEPTH nor underflow below 0.
REQ-027 The module SHALL detect no errors; aln_valid while aln_ready=0 SHALL be ignored, and the aligner holds its data.

Reset
REQ-028 While rst_l=0, asynchronously: ib_count=0, pointers=0, ifu_i0_valid=0, aln_ready=1, and all ifu_i0_* payload outputs=0.
REQ-029 Payload storage SHALL need no reset; it SHALL be unobservable while the entry is invalid.
REQ-030 Assertion of rst_l=0 mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-031 Basic: push instr 0x00B50533, pc 0x80000000>>1, pc4=1, with dec_ready=1 -> ifu_i0_valid=1 one cycle later with the same fields; ib_count returns to 0 after the pop.
REQ-032 Fill/stall: dec_ready=0, push 2 entries (A, B) with DEPTH=2 -> aln_ready=0, ib_count=2; a third push is ignored; release dec_ready -> outputs A then B.
REQ-033 Debug hold: ib_count=1 holding A, dbg_cmd_valid=1 and dec_ready=1 for 3 cycles -> A stays at the head, ib_count=1; drop dbg_cmd_valid -> A pops.
REQ-034 Flush priority: ib_count=1, flush=1 with a concurrent push C and a pop -> next cycle ib_count=0, ifu_i0_valid=0, payload outputs=0, and C is not stored.
REQ-035 Wrap: with DEPTH=4, stream 10 entries with simultaneous push and pop at occupancy 2 -> in-order delivery, ib_count constant at 2, and the fault fields (icaf=1, icaf_type=2'b10 on entry 7) preserved.
REQ-036 Reset mid-op: ib_count=2, drive rst_l=0 between edges -> ifu_i0_valid=0 and ib_count=0 immediately, and aln_ready=1.

Source files
------------

// File: rtl/el2_dec_ib_buf.sv
// rtl/el2_dec_ib_buf.sv - instruction buffer between aligner and decode
module el2_dec_ib_buf #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       aln_valid,
  input  logic [31:0]                aln_instr,
  input  logic [31:1]                aln_pc,
  input  logic                       aln_pc4,
  input  logic                       aln_icaf,
  input  logic                       aln_icaf_f1,
  input  logic                       aln_dbecc,
  input  logic [1:0]                 aln_icaf_type,
  output logic                       aln_ready,
  input  logic                       dec_ready,
  input  logic                       dbg_cmd_valid,
  input  logic                       flush,
  output logic                       ifu_i0_valid,
  output logic [31:0]                ifu_i0_instr,
  output logic [31:1]                ifu_i0_pc,
  output logic                       ifu_i0_pc4,
  output logic                       ifu_i0_icaf,
  output logic [1:0]                 ifu_i0_icaf_type,
  output logic                       ifu_i0_icaf_f1,
  output logic                       ifu_i0_dbecc,
  output logic [$clog2(DEPTH):0]     ib_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 69;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] wr_payload;
  logic [DW-1:0] head;
  logic          push;
  logic          pop;

  assign wr_payload = {aln_icaf_f1, aln_dbecc, aln_icaf, aln_icaf_type,
                       aln_pc, aln_pc4, aln_instr};

  // Ready and valid depend on the occupancy register only, so decode-side
  // inputs never reach aln_ready combinationally.
  assign aln_ready    = (count_q < CW'(DEPTH));
  assign ifu_i0_valid = (count_q != '0);
  assign ib_count     = count_q;

  assign push = aln_valid & aln_ready & ~flush;
  assign pop  = ifu_i0_valid & dec_ready & ~dbg_cmd_valid & ~flush;

  // Pointer and occupancy next-state; flush wipes everything and wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Payload write at the write pointer on a push.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_payload;
  end

  // Control state, cleared asynchronously so entries vanish the moment reset asserts.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are masked whenever the head is invalid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head entry, forced to zero while the buffer is empty.
  always_comb begin
    head = '0;
    if (ifu_i0_valid) head = mem_q[rd_ptr_q];
  end

  assign {ifu_i0_icaf_f1, ifu_i0_dbecc, ifu_i0_icaf, ifu_i0_icaf_type,
          ifu_i0_pc, ifu_i0_pc4, ifu_i0_instr} = head;

endmodule
